// File: rtl/div_sched_pkg.sv
// Shared types and defaults for the divider-stage scheduler.
package div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam int DEF_NLANES = 4;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_LAT    = 4;

  // Width of a binary lane index; never narrower than one bit.
  function automatic int lane_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_sched_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first eligible requester at or
// above the pointer wins, wrapping around past the top lane.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] rr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  // Candidate lane for each search offset, already wrapped into 0..N-1.
  logic [IW-1:0] cand [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum       = {1'b0, rr} + (IW+1)'(gi);
    assign cand[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
  end

  // Walk the offsets in priority order and keep the first eligible lane.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_gnt && elig[cand[k]]) begin
        any_gnt       = 1'b1;
        gnt[cand[k]]  = 1'b1;
        gnt_idx       = cand[k];
      end
    end
  end

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one fixed-latency divider stage among lanes.
// One operation is in the unit at a time; its result lands in the issuing
// lane's one-entry response register, and a lane with an unread result is
// not granted again until that result is taken.
module div_sched
  import div_sched_pkg::*;
#(
  parameter  int NLANES = DEF_NLANES,
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int LAT    = DEF_LAT,
  localparam int IW     = lane_idx_w(NLANES)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NLANES-1:0]       req_valid,
  input  logic [NLANES*WIDTH-1:0] req_data,
  output logic [NLANES-1:0]       req_ready,
  output logic                    unit_ld,
  output logic [WIDTH-1:0]        unit_s,
  input  logic [WIDTH-1:0]        unit_q,
  output logic [NLANES-1:0]       rsp_valid,
  output logic [NLANES*WIDTH-1:0] rsp_data,
  input  logic [NLANES-1:0]       rsp_ready,
  output logic                    busy,
  output logic [IW-1:0]           grant_id
);

  localparam int CW = $clog2(LAT + 1);

  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic [WIDTH-1:0]  op_reg;
  logic [IW-1:0]     rr_reg;
  logic [IW-1:0]     grant_id_reg;
  logic              rsp_valid_reg [NLANES];
  logic [WIDTH-1:0]  rsp_data_reg  [NLANES];
  logic [WIDTH-1:0]  req_word      [NLANES];

  logic [NLANES-1:0] eligible;
  logic [NLANES-1:0] arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;

  // A lane holding an unread result must not be granted, or it would be overwritten.
  assign eligible = req_valid & ~rsp_valid;

  rr_arbiter #(
    .N  (NLANES),
    .IW (IW)
  ) u_arb (
    .elig    (eligible),
    .rr      (rr_reg),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  assign req_ready = (state_reg == IDLE && !areset) ? arb_gnt : '0;
  assign unit_ld   = (state_reg == ISSUE);
  assign unit_s    = op_reg;
  assign busy      = (state_reg != IDLE);
  assign grant_id  = grant_id_reg;

  // Sequencer: grant, pulse the load, count out the latency, capture the result.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      op_reg       <= '0;
      rr_reg       <= '0;
      grant_id_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            op_reg       <= req_word[arb_idx];
            grant_id_reg <= arb_idx;
            rr_reg       <= (arb_idx == IW'(NLANES - 1)) ? '0 : arb_idx + 1'b1;
            state_reg    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= CW'(LAT - 1);
          state_reg <= WAIT;
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CW'(1)) begin
            state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    assign req_word[gi]                  = req_data[gi*WIDTH +: WIDTH];
    assign rsp_data[gi*WIDTH +: WIDTH]   = rsp_data_reg[gi];
    assign rsp_valid[gi]                 = rsp_valid_reg[gi];

    // Per-lane response slot: filled on capture for the owning lane, emptied on accept.
    always_ff @(posedge aclk) begin
      if (areset) begin
        rsp_valid_reg[gi] <= 1'b0;
        rsp_data_reg[gi]  <= '0;
      end else if (state_reg == CAPTURE && grant_id_reg == IW'(gi)) begin
        rsp_valid_reg[gi] <= 1'b1;
        rsp_data_reg[gi]  <= unit_q;
      end else if (rsp_ready[gi]) begin
        rsp_valid_reg[gi] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched: directed stimulus pushes expected grants and
// results; independent monitors compare whatever the scheduler presents.
module tb_div_sched;
  import div_sched_pkg::*;

  localparam int NL  = 4;
  localparam int W   = 32;
  localparam int LAT = 4;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NL-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NL*W-1:0]   req_data, rsp_data;
  logic              unit_ld, busy;
  logic [W-1:0]      unit_s, unit_q;
  logic [1:0]        grant_id;

  typedef struct { int lane; logic [31:0] data; } exp_t;

  exp_t          exp_rsp[$];
  int            exp_gnt[$];
  logic [W-1:0]  lane_q[NL][$];
  logic [W-1:0]  pipe[LAT];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            last_gnt_cyc = 0;
  bit            spacing_en = 0;
  bit            have_last = 0;

  div_sched #(.NLANES(NL), .WIDTH(W), .LAT(LAT)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .unit_ld(unit_ld), .unit_s(unit_s), .unit_q(unit_q),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .grant_id(grant_id)
  );

  initial forever #5 aclk = ~aclk;
  initial forever begin @(posedge aclk); cyc++; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Shared unit model: q = s >> 1, valid only in the LAT-th cycle after the load.
  assign unit_q = pipe[LAT-1];
  initial begin
    logic ld_s;
    logic [W-1:0] s_s;
    for (int k = 0; k < LAT; k++) pipe[k] = 32'hDEAD_BEEF;
    forever begin
      @(negedge aclk);
      ld_s = unit_ld;
      s_s  = unit_s;
      @(posedge aclk);
      #1;
      for (int k = LAT-1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = ld_s ? (s_s >> 1) : 32'hDEAD_BEEF;
    end
  end

  // Lane requesters: present the head of each lane queue, retire it once accepted.
  initial begin
    logic [NL-1:0] hs;
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge aclk);
      hs = req_valid & req_ready;
      @(posedge aclk);
      #2;
      for (int i = 0; i < NL; i++) begin
        if (hs[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
        if (lane_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[i*W +: W] = lane_q[i][0];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Grant monitor: every accept must match the next expected lane.
  initial forever begin
    @(negedge aclk);
    if (req_ready != '0) begin
      int idx;
      idx = 0;
      for (int i = NL-1; i >= 0; i--) if (req_ready[i]) idx = i;
      chk("grant_onehot", 32'($onehot(req_ready)), 1);
      if (exp_gnt.size() == 0) begin
        chk("unexpected_grant_lane", idx, 32'hFFFF_FFFF);
      end else begin
        chk("grant_lane", idx, exp_gnt.pop_front());
      end
      if (spacing_en && have_last) chk("grant_spacing", cyc - last_gnt_cyc, LAT + 2);
      last_gnt_cyc = cyc;
      have_last = 1;
    end
  end

  // Response monitor: each new result is popped and compared against the scoreboard.
  initial begin
    logic [NL-1:0] prev_rv;
    prev_rv = '0;
    forever begin
      @(negedge aclk);
      for (int i = 0; i < NL; i++) begin
        if (rsp_valid[i] && !prev_rv[i]) begin
          if (exp_rsp.size() == 0) begin
            chk("unexpected_rsp_lane", i, 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = exp_rsp.pop_front();
            chk("rsp_lane", i, e.lane);
            chk("rsp_data", rsp_data[i*W +: W], e.data);
          end
        end
      end
      prev_rv = rsp_valid;
    end
  end

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    do begin @(negedge aclk); n++; end while (req_ready == '0 && n < 40);
    chk({name, "_granted"}, 32'(req_ready != '0), 1);
  endtask

  task automatic wait_left(input string name, input int g_left, input int r_left);
    int n;
    n = 0;
    while ((exp_gnt.size() > g_left || exp_rsp.size() > r_left) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    @(negedge aclk);
    chk({name, "_pending"}, exp_gnt.size() + exp_rsp.size(), g_left + r_left);
  endtask

  task automatic reset_pulse();
    @(posedge aclk); #1 areset = 1'b1;
    @(posedge aclk); #1 areset = 1'b0;
  endtask

  initial begin
    areset    = 1'b1;
    rsp_ready = '1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_unit_ld", unit_ld, 0);
    chk("rst_unit_s", unit_s, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", req_ready, 0);
    @(posedge aclk); #1 areset = 1'b0;

    // Single request on lane 2 with cycle-exact timing.
    exp_gnt.push_back(2);
    exp_rsp.push_back('{2, 32'h0000_0008});
    lane_q[2].push_back(32'h0000_0010);
    wait_grant("single");
    chk("single_req_ready", req_ready, 4'b0100);
    for (int k = 1; k <= 6; k++) begin
      @(negedge aclk);
      chk($sformatf("single_unit_ld_t%0d", k), unit_ld, 32'(k == 1));
      chk($sformatf("single_busy_t%0d", k), busy, 32'(k <= 5));
      chk($sformatf("single_rsp_valid_t%0d", k), rsp_valid, (k == 6) ? 4'b0100 : 4'b0000);
      if (k == 1) begin
        chk("single_unit_s", unit_s, 32'h10);
        chk("single_grant_id", grant_id, 2);
      end
      if (k == 6) chk("single_rsp_data2", rsp_data[2*W +: W], 32'h8);
    end
    wait_left("single", 0, 0);

    // Fairness: every lane requesting, round robin from lane 0, 6 cycles apart.
    reset_pulse();
    spacing_en = 1;
    have_last  = 0;
    foreach (exp_gnt[i]) ;
    exp_gnt = '{0, 1, 2, 3, 0};
    exp_rsp.push_back('{0, 32'h80});
    exp_rsp.push_back('{1, 32'h180});
    exp_rsp.push_back('{2, 32'h200});
    exp_rsp.push_back('{3, 32'h280});
    exp_rsp.push_back('{0, 32'h100});
    lane_q[0].push_back(32'h100);
    lane_q[0].push_back(32'h200);
    lane_q[1].push_back(32'h300);
    lane_q[2].push_back(32'h400);
    lane_q[3].push_back(32'h500);
    wait_left("fair", 0, 0);
    spacing_en = 0;

    // Backpressure: lane 1 holds its result and is skipped until it is taken.
    rsp_ready = 4'b1101;
    exp_gnt = '{1, 2, 3, 0, 0, 1};
    exp_rsp.push_back('{1, 32'h300});
    exp_rsp.push_back('{2, 32'h500});
    exp_rsp.push_back('{3, 32'h580});
    exp_rsp.push_back('{0, 32'h400});
    exp_rsp.push_back('{0, 32'h480});
    exp_rsp.push_back('{1, 32'h380});
    lane_q[0].push_back(32'h800);
    lane_q[0].push_back(32'h900);
    lane_q[1].push_back(32'h600);
    lane_q[1].push_back(32'h700);
    lane_q[2].push_back(32'hA00);
    lane_q[3].push_back(32'hB00);
    wait_left("bp_partial", 1, 1);
    repeat (4) @(negedge aclk);
    chk("bp_idle_blocked", busy, 0);
    chk("bp_held_valid1", rsp_valid[1], 1);
    chk("bp_held_data1", rsp_data[1*W +: W], 32'h300);
    @(posedge aclk); #1 rsp_ready = 4'b1111;
    wait_left("bp", 0, 0);

    // Reset during the second WAIT cycle drops the operation.
    exp_gnt.push_back(2);
    lane_q[2].push_back(32'hC00);
    wait_grant("rstwait");
    @(posedge aclk); #1;
    lane_q[3].push_back(32'hD00);
    lane_q[1].push_back(32'hE00);
    exp_gnt.push_back(1);
    exp_gnt.push_back(3);
    exp_rsp.push_back('{1, 32'h700});
    exp_rsp.push_back('{3, 32'h680});
    @(posedge aclk);
    @(posedge aclk); #1 areset = 1'b1;
    @(negedge aclk);
    chk("rstwait_req_ready_in_reset", req_ready, 0);
    chk("rstwait_busy_before", busy, 1);
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    chk("rstwait_busy", busy, 0);
    chk("rstwait_rsp_valid", rsp_valid, 0);
    chk("rstwait_unit_ld", unit_ld, 0);
    chk("rstwait_unit_s", unit_s, 0);
    chk("rstwait_grant_id", grant_id, 0);
    wait_left("rstwait", 0, 0);

    // Lane 3 raises and withdraws its request while the unit is busy.
    exp_gnt.push_back(0);
    exp_rsp.push_back('{0, 32'h780});
    lane_q[0].push_back(32'hF00);
    wait_grant("withdraw");
    @(posedge aclk); #1 lane_q[3].push_back(32'h1111);
    @(posedge aclk);
    @(posedge aclk); #1 lane_q[3].delete();
    wait_left("withdraw", 0, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
      chk($sformatf("withdraw_unit_ld_%0d", k), unit_ld, 0);
      chk($sformatf("withdraw_req_ready_%0d", k), req_ready, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
